// File: rtl/mem_ctrl_pkg.sv
// Shared widths, address map, FSM encoding and access-length codes for the
// memory controller and its byte assembler.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / BYTE_W;

  localparam logic [31:0] IO_ADDR_DEF = 32'h0003_0000;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_MEM_RD,
    S_MEM_WR,
    S_DONE
  } state_t;

  // The unused code 2 is folded into a full word access.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Collects bytes returned by the RAM into little-endian lanes; o_word_next
// already contains the byte being captured this cycle.
module mem_byte_assembler
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic [BYTE_W-1:0] i_din,
  output logic [WORD_W-1:0] o_word_next
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_capture) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [BYTE_W-1:0] r_byte;
      logic [BYTE_W-1:0] w_byte_next;

      assign w_byte_next = (i_capture && (r_cnt == CNT_W'(gi))) ? i_din : r_byte;
      assign o_word_next[BYTE_W*gi +: BYTE_W] = w_byte_next;

      // Clearing at acceptance gives zero-extension of short loads for free.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_byte <= '0;
        end else if (i_en) begin
          r_byte <= i_clear ? '0 : w_byte_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mem_ctrl.sv
// Serialises fetch reads and MEM loads/stores onto the 8-bit RAM/IO bus and
// returns assembled little-endian words with one-cycle done pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_inst,
  output logic              if_enable,
  input  logic              jump_or_not,
  input  logic              mem_request,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_enable,
  input  logic [BYTE_W-1:0] ram_din,
  output logic [BYTE_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [2:0]          r_n, w_n_next;
  logic [WORD_W-1:0]   r_wdata, w_wdata_next;
  logic [2:0]          r_step, w_step_next;
  logic [ADDR_W-1:0]   r_ram_a, w_ram_a_next;
  logic [BYTE_W-1:0]   r_ram_dout, w_ram_dout_next;
  logic                r_ram_wr, w_ram_wr_next;
  logic [WORD_W-1:0]   r_if_inst, w_if_inst_next;
  logic [WORD_W-1:0]   r_mem_rdata, w_mem_rdata_next;
  logic                r_if_en, w_if_en_next;
  logic                r_mem_en, w_mem_en_next;
  logic [BYTE_W-1:0]   r_din_hold;
  logic                r_hold_valid;

  logic                w_clear, w_capture;
  logic [ADDR_W-1:0]   w_issue_a;
  logic [BYTE_W-1:0]   w_din_sel;
  logic [WORD_W-1:0]   w_word_next;

  assign w_issue_a = r_addr + ADDR_W'(r_step);
  // The RAM keeps running while rdy is low, so the byte answering the last
  // issued address is held from the first stalled cycle.
  assign w_din_sel = r_hold_valid ? r_din_hold : ram_din;

  mem_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_en       (rdy),
    .i_clear    (w_clear),
    .i_capture  (w_capture),
    .i_din      (w_din_sel),
    .o_word_next(w_word_next)
  );

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_n_next         = r_n;
    w_wdata_next     = r_wdata;
    w_step_next      = r_step;
    w_ram_a_next     = r_ram_a;
    w_ram_dout_next  = r_ram_dout;
    w_ram_wr_next    = 1'b0;
    w_if_inst_next   = r_if_inst;
    w_mem_rdata_next = r_mem_rdata;
    w_if_en_next     = 1'b0;
    w_mem_en_next    = 1'b0;
    w_clear          = 1'b0;
    w_capture        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (mem_request) begin
          if (!(mem_wr && io_buffer_full && (mem_addr >= IO_ADDR))) begin
            w_addr_next  = mem_addr;
            w_n_next     = byte_count(mem_len);
            w_wdata_next = mem_wdata;
            w_step_next  = 3'd1;
            w_ram_a_next = mem_addr;
            w_clear      = 1'b1;
            if (mem_wr) begin
              w_ram_dout_next = mem_wdata[BYTE_W-1:0];
              w_ram_wr_next   = 1'b1;
              w_state_next    = S_MEM_WR;
            end else begin
              w_state_next = S_MEM_RD;
            end
          end
        end else if (if_request && !jump_or_not) begin
          w_addr_next  = if_addr;
          w_n_next     = 3'(WORD_BYTES);
          w_step_next  = 3'd1;
          w_ram_a_next = if_addr;
          w_clear      = 1'b1;
          w_state_next = S_IF_RD;
        end
      end

      S_IF_RD, S_MEM_RD: begin
        if ((r_state == S_IF_RD) && jump_or_not) begin
          w_state_next = S_IDLE;
        end else begin
          if (r_step < r_n) w_ram_a_next = w_issue_a;
          // Byte k arrives two edges after its address was issued.
          if (r_step >= 3'd2) w_capture = 1'b1;
          if (r_step == r_n + 3'd1) begin
            w_state_next = S_DONE;
            if (r_state == S_IF_RD) begin
              w_if_inst_next = w_word_next;
              w_if_en_next   = 1'b1;
            end else begin
              w_mem_rdata_next = w_word_next;
              w_mem_en_next    = 1'b1;
            end
          end else begin
            w_step_next = r_step + 3'd1;
          end
        end
      end

      S_MEM_WR: begin
        if (r_step == r_n) begin
          w_state_next  = S_DONE;
          w_mem_en_next = 1'b1;
        end else if (!(io_buffer_full && (w_issue_a >= IO_ADDR))) begin
          w_ram_a_next    = w_issue_a;
          w_ram_dout_next = r_wdata[{r_step[1:0], 3'b000} +: BYTE_W];
          w_ram_wr_next   = 1'b1;
          w_step_next     = r_step + 3'd1;
        end
      end

      S_DONE: w_state_next = S_IDLE;

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_n          <= '0;
      r_wdata      <= '0;
      r_step       <= '0;
      r_ram_a      <= '0;
      r_ram_dout   <= '0;
      r_ram_wr     <= 1'b0;
      r_if_inst    <= '0;
      r_mem_rdata  <= '0;
      r_if_en      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_din_hold   <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      if (!rdy) begin
        if (!r_hold_valid) begin
          r_din_hold   <= ram_din;
          r_hold_valid <= 1'b1;
        end
      end else begin
        r_hold_valid <= 1'b0;
        r_state      <= w_state_next;
        r_addr       <= w_addr_next;
        r_n          <= w_n_next;
        r_wdata      <= w_wdata_next;
        r_step       <= w_step_next;
        r_ram_a      <= w_ram_a_next;
        r_ram_dout   <= w_ram_dout_next;
        r_ram_wr     <= w_ram_wr_next;
        r_if_inst    <= w_if_inst_next;
        r_mem_rdata  <= w_mem_rdata_next;
        r_if_en      <= w_if_en_next;
        r_mem_en     <= w_mem_en_next;
      end
    end
  end

  assign ram_a      = r_ram_a;
  assign ram_dout   = r_ram_dout;
  assign ram_wr     = r_ram_wr & rdy;
  // A flush arriving during the fetch pulse makes the instruction stale.
  assign if_enable  = r_if_en & ~jump_or_not;
  assign if_inst    = r_if_inst;
  assign mem_enable = r_mem_en;
  assign mem_rdata  = r_mem_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM model plus an expected-memory
// reference, directed scenarios and randomized loads/stores/fetches.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_request, jump_or_not, mem_request, mem_wr, io_buffer_full;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_inst, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din, ram_dout;
  logic        if_enable, mem_enable, ram_wr;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_request(if_request), .if_addr(if_addr), .if_inst(if_inst), .if_enable(if_enable),
    .jump_or_not(jump_or_not),
    .mem_request(mem_request), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_enable(mem_enable),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [39:0] wr_log  [$];
  logic        do_init;
  int          both_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  // RAM/IO bus model: one-cycle registered read, writes logged on the edge.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
    end else begin
      ram_din <= ram[ram_a[11:0]];
      if (ram_wr) begin
        wr_log.push_back({ram_a, ram_dout});
        if (ram_a < IO_BASE) ram[ram_a[11:0]] <= ram_dout;
      end
    end
  end

  always @(negedge clk) if (if_enable && mem_enable) both_cnt <= both_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] ak;
    w = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      w[8*k +: 8] = ref_mem[ak[11:0]];
    end
    return w;
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // Waits (bounded) for the wanted pulse; flags any pulse on the other port.
  task automatic wait_pulse(input bit is_if, output int cyc, output bit other_seen);
    cyc = 0;
    other_seen = 1'b0;
    while (cyc < 60) begin
      tick();
      cyc++;
      if (is_if ? mem_enable : if_enable) other_seen = 1'b1;
      if (is_if ? if_enable : mem_enable) break;
    end
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int cyc;
    bit oth;
    wr_log.delete();
    if_addr    = a;
    if_request = 1'b1;
    wait_pulse(1'b1, cyc, oth);
    if_request = 1'b0;
    check("if_inst", if_inst, ref_read(a, 4));
    check("if_lat", cyc, 6);
    check("if_no_write", wr_log.size(), 0);
    $display("txn fetch a=%h inst=%h lat=%0d", a, if_inst, cyc);
    tick();
  endtask

  task automatic do_mem(input bit wr, input logic [31:0] a, input logic [1:0] len,
                        input logic [31:0] wd);
    int cyc;
    int n;
    bit oth;
    logic [31:0] ak;
    n = len_bytes(len);
    wr_log.delete();
    mem_wr = wr; mem_addr = a; mem_len = len; mem_wdata = wd; mem_request = 1'b1;
    wait_pulse(1'b0, cyc, oth);
    mem_request = 1'b0;
    if (wr) begin
      check("st_lat", cyc, n + 1);
      check("st_count", wr_log.size(), n);
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        if (k < wr_log.size()) begin
          check("st_addr", wr_log[k][39:8], ak);
          check("st_data", {24'h0, wr_log[k][7:0]}, {24'h0, wd[8*k +: 8]});
        end
        if (ak < IO_BASE) ref_mem[ak[11:0]] = wd[8*k +: 8];
      end
      $display("txn store a=%h len=%0d wd=%h lat=%0d", a, len, wd, cyc);
    end else begin
      check("ld_data", mem_rdata, ref_read(a, n));
      check("ld_lat", cyc, n + 2);
      check("ld_no_write", wr_log.size(), 0);
      $display("txn load a=%h len=%0d rd=%h lat=%0d", a, len, mem_rdata, cyc);
    end
    tick();
  endtask

  initial begin
    int cyc;
    bit oth;
    int cnt;
    logic [31:0] wd;

    rst = 1'b1; rdy = 1'b1; if_request = 1'b0; jump_or_not = 1'b0; mem_request = 1'b0;
    mem_wr = 1'b0; io_buffer_full = 1'b0; if_addr = '0; mem_addr = '0; mem_len = '0;
    mem_wdata = '0; do_init = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h100] = 8'h13; ref_mem[12'h101] = 8'h05;
    ref_mem[12'h102] = 8'h10; ref_mem[12'h103] = 8'h00;
    ref_mem[12'h204] = 8'hFF;

    tick(); tick();
    do_init = 1'b0;
    check("rst_if_en", if_enable, 0);
    check("rst_mem_en", mem_enable, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    rst = 1'b0;
    tick();

    do_fetch(32'h100);
    check("fetch_word", if_inst, 32'h00100513);

    // Simultaneous requests: MEM wins, fetch follows after DONE.
    wr_log.delete();
    mem_wr = 1'b0; mem_addr = 32'h204; mem_len = 2'd0; mem_request = 1'b1;
    if_addr = 32'h100; if_request = 1'b1;
    wait_pulse(1'b0, cyc, oth);
    mem_request = 1'b0;
    check("arb_no_if_first", oth, 0);
    check("arb_rdata", mem_rdata, 32'h0000_00FF);
    check("arb_mem_lat", cyc, 3);
    wait_pulse(1'b1, cyc, oth);
    if_request = 1'b0;
    check("arb_if_inst", if_inst, 32'h00100513);
    check("arb_if_lat", cyc, 7);
    check("arb_no_write", wr_log.size(), 0);
    $display("txn arbitration load=%h fetch=%h", mem_rdata, if_inst);
    tick();

    do_mem(1'b1, 32'h300, 2'd1, 32'hABCD_1234);
    do_mem(1'b0, 32'h300, 2'd1, 32'h0);
    check("half_readback", mem_rdata, 32'h0000_1234);

    // Flush three edges into a fetch, then a new fetch right away.
    if_addr = 32'h100; if_request = 1'b1;
    tick(); tick(); tick();
    jump_or_not = 1'b1; if_addr = 32'h108;
    tick();
    check("flush_no_pulse", if_enable, 0);
    jump_or_not = 1'b0;
    wait_pulse(1'b1, cyc, oth);
    if_request = 1'b0;
    check("flush_new_lat", cyc, 6);
    check("flush_new_inst", if_inst, ref_read(32'h108, 4));
    $display("txn flush then fetch a=108 inst=%h lat=%0d", if_inst, cyc);
    tick();

    // IO backpressure on a byte store.
    wr_log.delete();
    io_buffer_full = 1'b1;
    mem_wr = 1'b1; mem_addr = IO_BASE; mem_len = 2'd0; mem_wdata = 32'h41; mem_request = 1'b1;
    cnt = 0;
    repeat (5) begin
      tick();
      if (ram_wr || mem_enable) cnt++;
    end
    check("io_held", cnt, 0);
    check("io_held_log", wr_log.size(), 0);
    io_buffer_full = 1'b0;
    wait_pulse(1'b0, cyc, oth);
    mem_request = 1'b0;
    check("io_lat", cyc, 2);
    check("io_count", wr_log.size(), 1);
    if (wr_log.size() > 0) begin
      check("io_addr", wr_log[0][39:8], IO_BASE);
      check("io_data", {24'h0, wr_log[0][7:0]}, 32'h41);
    end
    $display("txn io store writes=%0d lat=%0d", wr_log.size(), cyc);
    tick();

    // rdy low for 4 cycles in the middle of a word fetch.
    if_addr = 32'h100; if_request = 1'b1;
    tick(); tick(); tick();
    rdy = 1'b0;
    cnt = 0;
    repeat (4) begin
      tick();
      if (if_enable) cnt++;
    end
    check("stall_no_pulse", cnt, 0);
    rdy = 1'b1;
    wait_pulse(1'b1, cyc, oth);
    if_request = 1'b0;
    check("stall_lat", cyc + 7, 10);
    check("stall_inst", if_inst, 32'h00100513);
    $display("txn stalled fetch inst=%h lat=%0d", if_inst, cyc + 7);
    tick();

    // rdy low during a word store: no duplicated bus writes.
    wd = $urandom;
    wr_log.delete();
    mem_wr = 1'b1; mem_addr = 32'h500; mem_len = 2'd3; mem_wdata = wd; mem_request = 1'b1;
    tick();
    rdy = 1'b0;
    cnt = 0;
    repeat (2) begin
      tick();
      if (ram_wr) cnt++;
    end
    check("stall_wr_forced0", cnt, 0);
    rdy = 1'b1;
    wait_pulse(1'b0, cyc, oth);
    mem_request = 1'b0;
    check("stall_st_lat", cyc + 3, 7);
    check("stall_st_count", wr_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wr_log.size()) check("stall_st_data", {24'h0, wr_log[k][7:0]}, {24'h0, wd[8*k +: 8]});
      ref_mem[12'h500 + 12'(k)] = wd[8*k +: 8];
    end
    $display("txn stalled store wd=%h writes=%0d", wd, wr_log.size());
    tick();

    // Reset in the middle of a word store.
    wd = $urandom;
    wr_log.delete();
    mem_wr = 1'b1; mem_addr = 32'h600; mem_len = 2'd3; mem_wdata = wd; mem_request = 1'b1;
    tick(); tick();
    rst = 1'b1; mem_request = 1'b0;
    tick();
    check("rst_mid_wr", ram_wr, 0);
    check("rst_mid_a", ram_a, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick();
      if (mem_enable || ram_wr) cnt++;
    end
    check("rst_no_pulse", cnt, 0);
    check("rst_partial_count", wr_log.size(), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < wr_log.size()) check("rst_partial_data", {24'h0, wr_log[k][7:0]}, {24'h0, wd[8*k +: 8]});
      ref_mem[12'h600 + 12'(k)] = wd[8*k +: 8];
    end
    $display("txn reset mid-store writes=%0d", wr_log.size());

    // Address wrap past the top of the address space.
    do_mem(1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0);

    for (int t = 0; t < 30; t++) begin
      logic [31:0] ra;
      logic [1:0]  rl;
      int          op;
      op = $urandom_range(0, 2);
      ra = 32'($urandom_range(0, 4095));
      case ($urandom_range(0, 2))
        0: rl = 2'd0;
        1: rl = 2'd1;
        default: rl = 2'd3;
      endcase
      if (op == 0) do_fetch(ra & 32'hFFC);
      else do_mem(op == 2, ra, rl, $urandom);
    end

    check("no_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the fetch stage, the MEM stage and the 8-bit single-port RAM/IO bus.
- Accepts a 4-byte instruction read from fetch and 1/2/4-byte loads and stores from MEM.
- Serialises each access into byte cycles on the RAM bus and returns an assembled little-endian word with a one-cycle done pulse.
- Arbitrates between the two requesters; fetch reads are cancelled on a branch/jump flush.

Parameters:
- ADDR_W, 32, address width of both ports and of the RAM bus.
- IO_ADDR, 32'h00030000, first IO address; IO stores are gated by io_buffer_full.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global ready; low freezes all state
- if_request  input  1  fetch wants an instruction; held high until if_enable is seen
- if_addr  input  ADDR_W  instruction address (word aligned)
- if_inst  output  32  assembled instruction; valid only while if_enable=1
- if_enable  output  1  one-cycle pulse: if_inst valid
- jump_or_not  input  1  flush; cancels an in-flight fetch read
- mem_request  input  1  MEM-stage access request; held until mem_enable
- mem_wr  input  1  1=store, 0=load
- mem_addr  input  ADDR_W  byte address
- mem_len  input  2  byte count minus 1 (0=byte, 1=half, 3=word; 2 illegal)
- mem_wdata  input  32  store data, byte 0 = bits 7:0
- mem_rdata  output  32  load data, zero-extended; sign extension belongs to MEM
- mem_enable  output  1  one-cycle pulse: load data valid or store complete
- ram_din  input  8  RAM/IO read byte
- ram_dout  output  8  RAM/IO write byte
- ram_a  output  ADDR_W  RAM/IO byte address
- ram_wr  output  1  1=write this cycle
- io_buffer_full  input  1  IO output buffer full

Behaviour:
- Reset: state=IDLE; if_enable=0, mem_enable=0, ram_wr=0; ram_a, ram_dout, if_inst, mem_rdata all 0; byte counter=0.
- rdy=0: no register changes, except ram_wr is forced to 0 for that cycle.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration:
  - mem_request has priority over if_request.
  - The accepting edge E0 latches addr, len and wdata.
  - Nothing is accepted in the same cycle a done pulse is high.
- Read (IF_RD with N=4; MEM_RD with N=mem_len+1):
  - ram_a=addr+k is registered at edge Ek.
  - RAM latency is one cycle, so byte k is sampled at E(k+2) into bits 8k+7:8k.
  - At E(N+1) the last byte is sampled, the result is driven, state goes to DONE and the enable is raised.
  - The enable is high for the single cycle after E(N+1); the FSM returns to IDLE at E(N+2).
  - Latency: a word read pulses 6 cycles after E0.
- Write (MEM_WR):
  - At edges E0..E(N-1), ram_a=addr+k, ram_dout=wdata[8k+7:8k], ram_wr=1.
  - At EN: ram_wr=0, state goes to DONE and mem_enable pulses for one cycle.
  - If addr >= IO_ADDR and io_buffer_full=1 at the issuing edge, the FSM stays in IDLE/MEM_WR without writing until it clears; the byte index does not advance.
- Flush:
  - jump_or_not=1 in IF_RD or DONE-for-IF → IDLE at the next edge, if_enable forced 0, partial data discarded.
  - jump_or_not=1 in IDLE blocks IF acceptance that cycle.
  - MEM accesses are never cancelled.
- if_enable and mem_enable are never high together.
- if_inst and mem_rdata hold their last value outside the pulse.
- Address arithmetic wraps modulo 2^ADDR_W.
- mem_len=2 is treated as 3 (word); the bench never drives it.
- Mid-operation reset returns to IDLE with ram_wr=0 on the next edge; no partial completion pulse.

Decomposition:
- Shared config package: ADDR_W, word/byte widths, IO_ADDR, state encodings, mem_len codes.
- One natural sub-module, mem_byte_assembler: byte-lane shift register plus counter, reused by both read paths.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,10,00; if_request with if_addr=0x100 → if_enable pulses 6 cycles after acceptance, if_inst=32'h00100513, ram_wr never 1.
- Arbitration: mem_request load byte @0x204 (RAM=0xFF) and if_request raised on the same cycle → mem_enable first with mem_rdata=32'h000000FF; the IF read starts after DONE and completes correctly.
- Store half: mem_wr=1, mem_addr=0x300, mem_len=1, mem_wdata=0xABCD1234 → ram_wr high 2 cycles writing 0x34@0x300 then 0x12@0x301; mem_enable one cycle later; readback gives 0x1234.
- Flush: jump_or_not pulsed 3 cycles into an IF read → no if_enable, IDLE next edge; a new if_addr=0x108 then completes normally.
- IO backpressure: store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles → ram_wr stays 0; it writes exactly once after release, then mem_enable.
- rdy/reset: rdy low 4 cycles mid word read → result unchanged and latency +4; rst mid write → ram_wr=0 next cycle and no enable pulse.
